mem_wb_stage: RTL and testbench

MEM/WB pipeline register and writeback formatter for the 5-stage pipeline. It captures the MEM-stage result and extracts and extends load data by type and byte offset. It drives the register-file write port (`w_en`, `w_addr`, `w_data`) from registered state. It also blocks writes to `$0`, flags misaligned loads, and counts retired instructions.

---
 rtl/mem_wb_stage_if.sv | 25 ++
 rtl/mem_wb_stage.sv | 62 ++++++
 tb/tb_mem_wb_stage.sv | 119 +++++++++++
 3 files changed

// File: rtl/mem_wb_stage_if.sv
// mem_wb_stage_if: MEM-side inputs and register-file write-port outputs of the MEM/WB stage
interface mem_wb_stage_if;
  logic        stall;
  logic        flush;
  logic        mem_valid;
  logic        mem_wreg;
  logic [4:0]  mem_waddr;
  logic [31:0] mem_alu_result;
  logic [31:0] mem_rdata;
  logic [2:0]  mem_load_type;
  logic        w_en;
  logic [4:0]  w_addr;
  logic [31:0] w_data;
  logic        wb_valid;
  logic        wb_addr_err;
  logic [31:0] retired_cnt;
  modport master (
    output stall, flush, mem_valid, mem_wreg, mem_waddr, mem_alu_result, mem_rdata, mem_load_type,
    input  w_en, w_addr, w_data, wb_valid, wb_addr_err, retired_cnt
  );
  modport slave (
    input  stall, flush, mem_valid, mem_wreg, mem_waddr, mem_alu_result, mem_rdata, mem_load_type,
    output w_en, w_addr, w_data, wb_valid, wb_addr_err, retired_cnt
  );
endinterface

// File: rtl/mem_wb_stage.sv
// mem_wb_stage: MEM/WB register and load formatter; clk/rst plus bus (mem_* in, w_*/wb_*/retired_cnt out)
module mem_wb_stage (
  input  logic           clk,
  input  logic           rst,
  mem_wb_stage_if.slave  bus
);
  localparam logic [2:0] LT_LB  = 3'b001;
  localparam logic [2:0] LT_LBU = 3'b010;
  localparam logic [2:0] LT_LH  = 3'b011;
  localparam logic [2:0] LT_LHU = 3'b100;
  localparam logic [2:0] LT_LW  = 3'b101;
  logic        valid_q, valid_d, w_en_q, w_en_d, err_q, err_d;
  logic [4:0]  w_addr_q, w_addr_d;
  logic [31:0] w_data_q, w_data_d, cnt_q, cnt_d, fmt;
  logic [1:0]  off;
  logic [7:0]  b;
  logic [15:0] h;
  logic        misal;
  logic [2:0]  lt;
  always_comb begin
    lt    = bus.mem_load_type;
    off   = bus.mem_alu_result[1:0];
    b     = bus.mem_rdata[{off, 3'b000} +: 8];
    h     = off[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];
    misal = ((lt == LT_LH || lt == LT_LHU) && off[0]) || (lt == LT_LW && off != 2'b00);
    fmt   = lt == LT_LB  ? {{24{b[7]}}, b} :
            lt == LT_LBU ? {24'h0, b} :
            lt == LT_LH  ? {{16{h[15]}}, h} :
            lt == LT_LHU ? {16'h0, h} :
            lt == LT_LW  ? bus.mem_rdata : bus.mem_alu_result;
    valid_d  = bus.flush ? 1'b0  : bus.stall ? valid_q  : bus.mem_valid;
    w_en_d   = bus.flush ? 1'b0  : bus.stall ? w_en_q   :
               bus.mem_valid & bus.mem_wreg & (bus.mem_waddr != 5'd0) & ~misal;
    err_d    = bus.flush ? 1'b0  : bus.stall ? err_q    : bus.mem_valid & misal;
    w_addr_d = bus.flush ? 5'd0  : bus.stall ? w_addr_q : bus.mem_waddr;
    w_data_d = bus.flush ? 32'h0 : bus.stall ? w_data_q : fmt;
    cnt_d    = (bus.flush || bus.stall) ? cnt_q : cnt_q + {31'h0, bus.mem_valid};
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q  <= 1'b0;
      w_en_q   <= 1'b0;
      err_q    <= 1'b0;
      w_addr_q <= 5'd0;
      w_data_q <= 32'h0;
      cnt_q    <= 32'h0;
    end else begin
      valid_q  <= valid_d;
      w_en_q   <= w_en_d;
      err_q    <= err_d;
      w_addr_q <= w_addr_d;
      w_data_q <= w_data_d;
      cnt_q    <= cnt_d;
    end
  end
  assign bus.wb_valid    = valid_q;
  assign bus.w_en        = w_en_q;
  assign bus.wb_addr_err = err_q;
  assign bus.w_addr      = w_addr_q;
  assign bus.w_data      = w_data_q;
  assign bus.retired_cnt = cnt_q;
endmodule

// File: tb/tb_mem_wb_stage.sv
// tb_mem_wb_stage: directed self-checking bench for mem_wb_stage
module tb_mem_wb_stage;
  logic clk = 1'b0;
  logic rst;
  int checks = 0;
  int failures = 0;
  mem_wb_stage_if bus ();
  mem_wb_stage dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, obs, exp);
    end
  endtask
  task automatic drive(input logic v, input logic [4:0] wa, input logic [2:0] lt, input logic [31:0] alu);
    bus.mem_valid      = v;
    bus.mem_wreg       = 1'b1;
    bus.mem_waddr      = wa;
    bus.mem_load_type  = lt;
    bus.mem_alu_result = alu;
  endtask
  task automatic cyc();
    @(negedge clk);
  endtask
  typedef struct { logic [2:0] lt; logic [31:0] alu; logic [31:0] exp; } ld_t;
  ld_t lds[5] = '{
    '{3'b001, 32'h0000_1003, 32'hFFFF_FF80},
    '{3'b010, 32'h0000_1003, 32'h0000_0080},
    '{3'b011, 32'h0000_1002, 32'hFFFF_80FF},
    '{3'b100, 32'h0000_1000, 32'h0000_7F01},
    '{3'b101, 32'h0000_1000, 32'h80FF_7F01}
  };
  initial begin
    rst = 1'b1;
    bus.stall = 1'b0;
    bus.flush = 1'b0;
    bus.mem_rdata = 32'h0;
    drive(1'b1, 5'd9, 3'b000, 32'h0000_00AA);
    cyc();
    cyc();
    check("rst_valid", {31'h0, bus.wb_valid}, 32'h0);
    check("rst_wen", {31'h0, bus.w_en}, 32'h0);
    check("rst_err", {31'h0, bus.wb_addr_err}, 32'h0);
    check("rst_waddr", {27'h0, bus.w_addr}, 32'h0);
    check("rst_wdata", bus.w_data, 32'h0);
    check("rst_cnt", bus.retired_cnt, 32'h0);
    rst = 1'b0;
    drive(1'b1, 5'd9, 3'b000, 32'hAAAA_0001);
    cyc();
    check("first_cnt", bus.retired_cnt, 32'd1);
    check("first_wdata", bus.w_data, 32'hAAAA_0001);
    check("first_wen", {31'h0, bus.w_en}, 32'h1);
    bus.mem_rdata = 32'h80FF_7F01;
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 5'd9, lds[i].lt, lds[i].alu);
      cyc();
      check($sformatf("ld%0d_wdata", i), bus.w_data, lds[i].exp);
      check($sformatf("ld%0d_wen", i), {31'h0, bus.w_en}, 32'h1);
      check($sformatf("ld%0d_waddr", i), {27'h0, bus.w_addr}, 32'd9);
      check($sformatf("ld%0d_cnt", i), bus.retired_cnt, 32'd2 + i);
    end
    drive(1'b1, 5'd9, 3'b101, 32'h0000_1002);
    cyc();
    check("mis_lw_wen", {31'h0, bus.w_en}, 32'h0);
    check("mis_lw_err", {31'h0, bus.wb_addr_err}, 32'h1);
    check("mis_lw_cnt", bus.retired_cnt, 32'd7);
    drive(1'b0, 5'd9, 3'b000, 32'h0);
    cyc();
    check("mis_clr_err", {31'h0, bus.wb_addr_err}, 32'h0);
    check("bubble_valid", {31'h0, bus.wb_valid}, 32'h0);
    check("bubble_cnt", bus.retired_cnt, 32'd7);
    drive(1'b1, 5'd9, 3'b011, 32'h0000_1001);
    cyc();
    check("mis_lh_wen", {31'h0, bus.w_en}, 32'h0);
    check("mis_lh_err", {31'h0, bus.wb_addr_err}, 32'h1);
    check("mis_lh_cnt", bus.retired_cnt, 32'd8);
    drive(1'b1, 5'd0, 3'b000, 32'h0000_1234);
    cyc();
    check("r0_wen", {31'h0, bus.w_en}, 32'h0);
    check("r0_valid", {31'h0, bus.wb_valid}, 32'h1);
    check("r0_err", {31'h0, bus.wb_addr_err}, 32'h0);
    check("r0_cnt", bus.retired_cnt, 32'd9);
    drive(1'b1, 5'd5, 3'b000, 32'h0000_5555);
    cyc();
    check("pre_stall_cnt", bus.retired_cnt, 32'd10);
    bus.stall = 1'b1;
    drive(1'b1, 5'd7, 3'b000, 32'h0000_0000);
    for (int i = 0; i < 3; i++) begin
      cyc();
      check($sformatf("stall%0d_wdata", i), bus.w_data, 32'h0000_5555);
      check($sformatf("stall%0d_waddr", i), {27'h0, bus.w_addr}, 32'd5);
      check($sformatf("stall%0d_wen", i), {31'h0, bus.w_en}, 32'h1);
      check($sformatf("stall%0d_cnt", i), bus.retired_cnt, 32'd10);
    end
    bus.flush = 1'b1;
    cyc();
    check("flush_valid", {31'h0, bus.wb_valid}, 32'h0);
    check("flush_wen", {31'h0, bus.w_en}, 32'h0);
    check("flush_wdata", bus.w_data, 32'h0);
    check("flush_cnt", bus.retired_cnt, 32'd10);
    bus.flush = 1'b0;
    rst = 1'b1;
    cyc();
    check("rst_stall_cnt", bus.retired_cnt, 32'h0);
    rst = 1'b0;
    bus.stall = 1'b0;
    drive(1'b1, 5'd3, 3'b000, 32'h0000_0042);
    force dut.cnt_q = 32'hFFFF_FFFF;
    #1 release dut.cnt_q;
    #1 check("wrap_pre", bus.retired_cnt, 32'hFFFF_FFFF);
    cyc();
    check("wrap_cnt", bus.retired_cnt, 32'h0);
    check("wrap_valid", {31'h0, bus.wb_valid}, 32'h1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
